// File: rtl/cond_unit_mt.sv
// rtl/cond_unit_mt.sv - multi-context ARM condition unit with latched CondEx and gated write enables
// Optional per-context flag shadow for exception entry/return is built when COND_SHADOW_EN is defined.
module cond_unit_mt #(
    parameter int NCTX = 4,
    parameter int CTXW = $clog2(NCTX)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CTXW-1:0] CtxSel,
    input  logic [3:0]      Cond,
    input  logic [3:0]      ALUFlags,
    input  logic [1:0]      FlagW,
    input  logic            CondLatch,
    input  logic            FlagUpd,
    input  logic            PCS,
    input  logic            NextPC,
    input  logic            RegW,
    input  logic            MemW,
    input  logic            SaveFlags,
    input  logic            RestoreFlags,
    output logic            PCWrite,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            CondExOut,
    output logic [3:0]      FlagsOut
);

    logic [3:0]      flags     [NCTX];
    logic [3:0]      flags_nxt [NCTX];
    logic [3:0]      cur_flags;
    logic            cond_ex;
    logic            cond_ex_q;
    logic [CTXW-1:0] ctx_q;
    logic [1:0]      fw_q;
    logic            n_f, z_f, c_f, v_f;

    assign cur_flags = flags[CtxSel];
    assign {n_f, z_f, c_f, v_f} = cur_flags;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // A new latch overrides the post-update clear so back-to-back instructions keep their gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_ex_q <= 1'b0;
            ctx_q     <= '0;
            fw_q      <= 2'b00;
        end else if (CondLatch) begin
            cond_ex_q <= cond_ex;
            ctx_q     <= CtxSel;
            fw_q      <= FlagW & {2{cond_ex}};
        end else if (FlagUpd) begin
            fw_q      <= 2'b00;
        end
    end

`ifdef COND_SHADOW_EN
    logic [3:0] shadow [NCTX];

    // Shadow samples the pre-update flags; a same-cycle restore still reads the old shadow (swap).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCTX; i++) shadow[i] <= 4'b0000;
        end else if (SaveFlags) begin
            shadow[CtxSel] <= cur_flags;
        end
    end
`else
    logic unused_shadow_ctl;
    assign unused_shadow_ctl = ^{SaveFlags, RestoreFlags};
`endif

    always_comb begin
        for (int i = 0; i < NCTX; i++) begin
            flags_nxt[i] = flags[i];
            if (FlagUpd && (ctx_q == CTXW'(i))) begin
                if (fw_q[1]) flags_nxt[i][3:2] = ALUFlags[3:2];
                if (fw_q[0]) flags_nxt[i][1:0] = ALUFlags[1:0];
            end
`ifdef COND_SHADOW_EN
            if (RestoreFlags && (CtxSel == CTXW'(i))) flags_nxt[i] = shadow[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCTX; i++) flags[i] <= 4'b0000;
        end else begin
            for (int i = 0; i < NCTX; i++) flags[i] <= flags_nxt[i];
        end
    end

    assign RegWrite  = RegW & cond_ex_q;
    assign MemWrite  = MemW & cond_ex_q;
    assign PCWrite   = NextPC | (PCS & cond_ex_q);
    assign CondExOut = cond_ex_q;
    assign FlagsOut  = cur_flags;

endmodule

// File: tb/tb_cond_unit_mt.sv
// tb/tb_cond_unit_mt.sv - vector, directed and random checks of cond_unit_mt against a flag model
module tb_cond_unit_mt;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] ctx_sel = '0;
    logic [3:0] cond = '0, alu = '0;
    logic [1:0] flag_w = '0;
    logic       cond_latch = 0, flag_upd = 0, pcs = 0, next_pc = 0;
    logic       reg_w = 0, mem_w = 0, save_f = 0, restore_f = 0;
    logic       pc_write, reg_write, mem_write, cond_ex_out;
    logic [3:0] flags_out;
    logic [7:0] dut_o;

    int total = 0;
    int bad = 0;

    cond_unit_mt #(.NCTX(4)) dut (
        .clk(clk), .reset(reset), .CtxSel(ctx_sel), .Cond(cond), .ALUFlags(alu),
        .FlagW(flag_w), .CondLatch(cond_latch), .FlagUpd(flag_upd), .PCS(pcs),
        .NextPC(next_pc), .RegW(reg_w), .MemW(mem_w), .SaveFlags(save_f),
        .RestoreFlags(restore_f), .PCWrite(pc_write), .RegWrite(reg_write),
        .MemWrite(mem_write), .CondExOut(cond_ex_out), .FlagsOut(flags_out)
    );

    always #5 clk = ~clk;

    assign dut_o = {pc_write, reg_write, mem_write, cond_ex_out, flags_out};

    // Reference state: per-context flags and shadow, plus the instruction in flight.
    logic [3:0] m_flags [4];
    logic [3:0] m_shadow [4];
    logic       m_cx;
    int         m_ctx;
    logic [1:0] m_fw;

    // Even codes test a base predicate, odd codes its inverse; 1111 is the inverse of "always".
    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [7:0] model_o();
        return {next_pc | (pcs & m_cx), reg_w & m_cx, mem_w & m_cx, m_cx, m_flags[ctx_sel]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_flags[i]  = 4'b0000;
            m_shadow[i] = 4'b0000;
        end
        m_cx = 0; m_ctx = 0; m_fw = 2'b00;
    endtask

    task automatic model_edge();
        logic [3:0] nf [4];
        logic [3:0] ns [4];
        logic [3:0] keep;
        for (int i = 0; i < 4; i++) begin
            nf[i] = m_flags[i];
            ns[i] = m_shadow[i];
        end
        if (flag_upd) begin
            keep = {~m_fw[1], ~m_fw[1], ~m_fw[0], ~m_fw[0]};
            nf[m_ctx] = (m_flags[m_ctx] & keep) | (alu & ~keep);
        end
`ifdef COND_SHADOW_EN
        if (restore_f) nf[ctx_sel] = m_shadow[ctx_sel];
        if (save_f)    ns[ctx_sel] = m_flags[ctx_sel];
`endif
        if (cond_latch) begin
            m_cx  = cond_true(cond, m_flags[ctx_sel]);
            m_ctx = int'(ctx_sel);
            m_fw  = m_cx ? flag_w : 2'b00;
        end else if (flag_upd) begin
            m_fw = 2'b00;
        end
        for (int i = 0; i < 4; i++) begin
            m_flags[i]  = nf[i];
            m_shadow[i] = ns[i];
        end
    endtask

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got pc/reg/mem/cx/flags=%b required=%b", name, $time, got, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] c_ctx, input logic [3:0] c_cond, input logic [3:0] c_alu,
                          input logic [1:0] c_fw, input logic c_lat, input logic c_upd,
                          input logic c_pcs, input logic c_npc, input logic c_regw, input logic c_memw,
                          input logic c_save, input logic c_rest);
        ctx_sel = c_ctx; cond = c_cond; alu = c_alu; flag_w = c_fw;
        cond_latch = c_lat; flag_upd = c_upd; pcs = c_pcs; next_pc = c_npc;
        reg_w = c_regw; mem_w = c_memw; save_f = c_save; restore_f = c_rest;
    endtask

    task automatic run_cycle(input logic has_exp, input logic [7:0] exp, input string name);
        #1;
        cmp({name, "/model"}, dut_o, model_o());
        if (has_exp) cmp(name, dut_o, exp);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_pulse(input string name);
        reset = 1'b0;
        #1;
        model_clear();
        cmp(name, dut_o, {next_pc, 7'b0000000});
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0] ctx;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       lat, upd, pcs, npc, regw, memw;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [1:0] c, input logic [3:0] cd, input logic [3:0] a,
                                input logic [1:0] w, input logic l, input logic u, input logic p,
                                input logic np, input logic r, input logic m, input logic [7:0] e);
        vec_t v;
        v.ctx = c; v.cond = cd; v.alu = a; v.fw = w; v.lat = l; v.upd = u;
        v.pcs = p; v.npc = np; v.regw = r; v.memw = m; v.exp = e;
        return v;
    endfunction

    logic shadow_on;

    initial begin
`ifdef COND_SHADOW_EN
        shadow_on = 1'b1;
`else
        shadow_on = 1'b0;
`endif
        // ctx cond alu fw lat upd pcs npc regw memw  expected {pc,reg,mem,cx,flags}
        vt.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0, 8'b0000_0000));
        vt.push_back(mk(0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0, 8'b0000_0000));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 1, 8'b0111_0000));
        vt.push_back(mk(2, 4'b1110, 4'b0100, 2'b11, 1, 0, 0, 0, 0, 0, 8'b0001_0000));
        vt.push_back(mk(2, 4'b0000, 4'b0100, 2'b00, 0, 1, 0, 0, 0, 0, 8'b0001_0000));
        vt.push_back(mk(2, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 8'b0001_0100));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 8'b0001_0000));
        vt.push_back(mk(3, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        vt.push_back(mk(1, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 8'b0000_0000));
        vt.push_back(mk(1, 4'b0000, 4'b0111, 2'b00, 0, 1, 0, 0, 0, 0, 8'b0001_0000));
        vt.push_back(mk(1, 4'b1110, 4'b0000, 2'b10, 1, 0, 0, 0, 0, 0, 8'b0001_0111));
        vt.push_back(mk(1, 4'b0000, 4'b1011, 2'b00, 0, 1, 0, 0, 0, 0, 8'b0001_0111));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 8'b0001_1011));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 8'b0000_1011));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0, 8'b1000_1011));
        vt.push_back(mk(1, 4'b1110, 4'b0000, 2'b00, 1, 0, 1, 0, 0, 0, 8'b0000_1011));
        vt.push_back(mk(1, 4'b1111, 4'b0000, 2'b00, 1, 0, 1, 0, 0, 0, 8'b1001_1011));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 8'b0000_1011));
        vt.push_back(mk(0, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 8'b0000_0000));
        vt.push_back(mk(0, 4'b0000, 4'b1100, 2'b00, 0, 1, 0, 0, 0, 0, 8'b0001_0000));
        vt.push_back(mk(0, 4'b0000, 4'b0011, 2'b00, 0, 1, 0, 0, 0, 0, 8'b0001_1100));
        vt.push_back(mk(0, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 8'b0001_1100));
        vt.push_back(mk(3, 4'b1110, 4'b0001, 2'b01, 1, 1, 0, 0, 0, 0, 8'b0001_0000));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 8'b0001_0001));
        vt.push_back(mk(3, 4'b0000, 4'b1111, 2'b00, 0, 1, 0, 0, 0, 0, 8'b0001_0000));
        vt.push_back(mk(3, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 8'b0001_0011));

        model_clear();
        set_in(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0);
        reset_pulse("reset_outs");

        for (int k = 0; k < vt.size(); k++) begin
            set_in(vt[k].ctx, vt[k].cond, vt[k].alu, vt[k].fw, vt[k].lat, vt[k].upd,
                   vt[k].pcs, vt[k].npc, vt[k].regw, vt[k].memw, 0, 0);
            run_cycle(1'b1, vt[k].exp, $sformatf("vec%0d", k));
        end

        // Reset while an instruction's flag write is still pending.
        set_in(0, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b0, 8'h00, "pend_latch");
        set_in(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0);
        reset_pulse("mid_reset_outs");
        set_in(0, 4'b0000, 4'b1111, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b0, 8'h00, "post_reset_upd");
        set_in(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0);
        run_cycle(1'b1, 8'b0000_0000, "post_reset_flags");
        set_in(0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0);
        run_cycle(1'b1, 8'b0000_0000, "post_reset_eq");
        set_in(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle(1'b1, 8'b0101_0000, "post_reset_ne");

        // Shadow save / overwrite / restore on context 1.
        set_in(1, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b0, 8'h00, "sh_latch1");
        set_in(1, 4'b0000, 4'b1001, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b0, 8'h00, "sh_upd1");
        set_in(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        run_cycle(1'b1, 8'b0001_1001, "sh_save");
        set_in(1, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b0, 8'h00, "sh_latch2");
        set_in(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b0, 8'h00, "sh_upd2");
        set_in(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        run_cycle(1'b1, 8'b0001_0000, "sh_restore_req");
        set_in(1, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b1, shadow_on ? 8'b0001_1001 : 8'b0001_0000, "sh_restored");
        set_in(1, 4'b0000, 4'b0110, 2'b00, 0, 1, 0, 0, 0, 0, 0, 1);
        run_cycle(1'b0, 8'h00, "sh_restore_upd");
        set_in(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1'b1, shadow_on ? 8'b0001_1001 : 8'b0001_0110, "sh_restore_wins");

        for (int k = 0; k < 3000; k++) begin
            set_in(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 299) == 0) reset_pulse("rand_reset");
            else run_cycle(1'b0, 8'h00, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
